// File: rtl/streaming_unary_reduce.sv
// Streaming unary reduction: folds a multi-beat packet of N-bit words into one result bit
// using AND/OR/XOR (optionally inverted), with valid/ready on both sides.
module streaming_unary_reduce #(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic          in_last,
    input  logic [2:0]    op,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_result,
    output logic [CW-1:0] out_beats,
    output logic          out_ovf,
    output logic          out_err
);

    typedef enum logic [0:0] {StIdle, StAccum} state_e;

    localparam logic [CW-1:0] CntMax = '1;

    state_e          state_q, state_d;
    logic            acc_q;
    logic [CW-1:0]   cnt_q;
    logic            ovf_q;
    logic [2:0]      op_q;
    logic            out_valid_q;
    logic            out_result_q;
    logic [CW-1:0]   out_beats_q;
    logic            out_ovf_q;
    logic            out_err_q;

    logic            accept;
    logic            consume;
    logic [2:0]      eff_op;
    logic            reserved;
    logic            red;
    logic            acc_init;
    logic            acc_base;
    logic            acc_next;
    logic            res_next;
    logic [CW-1:0]   cnt_next;
    logic            ovf_next;

    assign accept  = in_valid && in_ready;
    assign consume = out_valid_q && out_ready;

    // The first beat of a packet uses the live op; later beats use the latched one.
    always_comb begin
        eff_op   = (state_q == StIdle) ? op : op_q;
        reserved = (eff_op[1:0] == 2'b11);
        red      = 1'b0;
        acc_init = 1'b0;
        unique case (eff_op[1:0])
            2'b00: begin
                red      = &in_data;
                acc_init = 1'b1;
            end
            2'b01:   red = |in_data;
            2'b10:   red = ^in_data;
            default: red = 1'b0;
        endcase
        acc_base = (state_q == StIdle) ? acc_init : acc_q;
        unique case (eff_op[1:0])
            2'b00:   acc_next = acc_base & red;
            2'b01:   acc_next = acc_base | red;
            2'b10:   acc_next = acc_base ^ red;
            default: acc_next = 1'b0;
        endcase
        res_next = reserved ? 1'b0 : (acc_next ^ eff_op[2]);
        if (state_q == StIdle) begin
            cnt_next = CW'(1);
            ovf_next = 1'b0;
        end else begin
            cnt_next = (cnt_q == CntMax) ? cnt_q : cnt_q + CW'(1);
            ovf_next = ovf_q | (cnt_q == CntMax);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = in_last ? StIdle : StAccum;
        end
    end

    always_comb begin
        in_ready   = !out_valid_q || out_ready;
        out_valid  = out_valid_q;
        out_result = out_result_q;
        out_beats  = out_beats_q;
        out_ovf    = out_ovf_q;
        out_err    = out_err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q        <= 1'b0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            op_q         <= 3'b000;
            out_valid_q  <= 1'b0;
            out_result_q <= 1'b0;
            out_beats_q  <= '0;
            out_ovf_q    <= 1'b0;
            out_err_q    <= 1'b0;
        end else if (accept && in_last) begin
            acc_q        <= 1'b0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            op_q         <= eff_op;
            out_valid_q  <= 1'b1;
            out_result_q <= res_next;
            out_beats_q  <= cnt_next;
            out_ovf_q    <= ovf_next;
            out_err_q    <= reserved;
        end else begin
            if (accept) begin
                acc_q <= acc_next;
                cnt_q <= cnt_next;
                ovf_q <= ovf_next;
                op_q  <= eff_op;
            end
            if (consume) begin
                out_valid_q <= 1'b0;
            end
        end
    end

endmodule
